// File: rtl/fizzbuzz_pkg.sv
// Shared types and default periods for the fizzbuzz stream monitor.
package fizzbuzz_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } fbm_state_t;

  localparam int DEF_FIZZ = 3;
  localparam int DEF_BUZZ = 5;

endpackage

// File: rtl/fizzbuzz_phase_ctr.sv
// Mod-N phase counter; wrap_next flags that the next advance returns to zero.
module fizzbuzz_phase_ctr #(
  parameter int  N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap_next
);

  logic [W-1:0] r_cnt;

  assign cnt       = r_cnt;
  assign wrap_next = (r_cnt == W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap_next ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/fizzbuzz_monitor.sv
// Receive-side checker: locks onto the fizz/buzz phase at a 1/1/1 sample,
// then predicts every later valid sample and counts deviations.
module fizzbuzz_monitor
  import fizzbuzz_pkg::*;
#(
  parameter int  FIZZ       = DEF_FIZZ,
  parameter int  BUZZ       = DEF_BUZZ,
  parameter int  MAX_CYCLES = 100,
  parameter int  ERR_W      = 8,
  localparam int IDX_W      = $clog2(MAX_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             fizz,
  input  logic             buzz,
  input  logic             fizzbuzz,
  output logic             locked,
  output logic [IDX_W-1:0] index,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);

  localparam int FPH_W = (FIZZ > 1) ? $clog2(FIZZ) : 1;
  localparam int BPH_W = (BUZZ > 1) ? $clog2(BUZZ) : 1;

  fbm_state_t       r_state;
  logic             r_locked;
  logic [IDX_W-1:0] r_index;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_errCount;

  logic [FPH_W-1:0] w_fph;
  logic [BPH_W-1:0] w_bph;
  logic             w_fWrap;
  logic             w_bWrap;
  logic             w_isLocked;
  logic             w_sync;
  logic             w_wellFormed;
  logic             w_expFb;
  logic             w_match;
  logic             w_phEn;
  logic             w_phClr;
  logic             w_errEvt;

  assign w_isLocked   = (r_state == LOCKED);
  assign w_sync       = fizz & buzz & fizzbuzz;
  assign w_wellFormed = (fizzbuzz == (fizz & buzz));

  // A phase counter about to wrap means the next sample must carry that flag.
  assign w_expFb  = w_fWrap & w_bWrap;
  assign w_match  = ({fizz, buzz, fizzbuzz} == {w_fWrap, w_bWrap, w_expFb});
  assign w_phEn   = valid & w_isLocked & w_match;
  assign w_phClr  = valid & (w_isLocked ? ~w_match : w_sync);
  assign w_errEvt = valid & (w_isLocked ? ~w_match : ~w_wellFormed);

  fizzbuzz_phase_ctr #(.N(FIZZ)) u_fizzPhase (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_phClr),
    .en        (w_phEn),
    .cnt       (w_fph),
    .wrap_next (w_fWrap)
  );

  fizzbuzz_phase_ctr #(.N(BUZZ)) u_buzzPhase (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_phClr),
    .en        (w_phEn),
    .cnt       (w_bph),
    .wrap_next (w_bWrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HUNT;
      r_locked   <= 1'b0;
      r_index    <= '0;
      r_mismatch <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_mismatch <= w_errEvt;
      if (w_errEvt && (r_errCount != {ERR_W{1'b1}})) begin
        r_errCount <= r_errCount + ERR_W'(1);
      end
      if (valid) begin
        case (r_state)
          HUNT: begin
            if (w_sync) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_index  <= '0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_index <= w_expFb ? '0 : r_index + IDX_W'(1);
            end else begin
              // An early 1/1/1 is taken as a fresh phase reference rather than a loss of lock.
              r_index <= '0;
              if (!w_sync) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign index     = r_index;
  assign mismatch  = r_mismatch;
  assign err_count = r_errCount;

  logic w_unusedPhase;
  assign w_unusedPhase = ^{w_fph, w_bph};

endmodule

// File: tb/tb_fizzbuzz_monitor.sv
// Randomised and directed bench for fizzbuzz_monitor against a sample-count reference model.
module tb_fizzbuzz_monitor;

  localparam int FIZZ  = 3;
  localparam int BUZZ  = 5;
  localparam int IDX_W = 8;

  logic clk;
  logic reset;
  logic valid;
  logic fizz;
  logic buzz;
  logic fizzbuzz;

  logic             lockedA;
  logic [IDX_W-1:0] indexA;
  logic             mismatchA;
  logic [7:0]       errA;
  logic             lockedB;
  logic [IDX_W-1:0] indexB;
  logic             mismatchB;
  logic [1:0]       errB;

  int assertCount;
  int failCount;

  // Reference model: samples since the last lock point, lock flag, unbounded error total.
  bit modelLocked;
  int modelK;
  int modelErrs;
  bit modelMis;

  fizzbuzz_monitor #(.FIZZ(FIZZ), .BUZZ(BUZZ), .MAX_CYCLES(100), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .fizz      (fizz),
    .buzz      (buzz),
    .fizzbuzz  (fizzbuzz),
    .locked    (lockedA),
    .index     (indexA),
    .mismatch  (mismatchA),
    .err_count (errA)
  );

  fizzbuzz_monitor #(.FIZZ(FIZZ), .BUZZ(BUZZ), .MAX_CYCLES(100), .ERR_W(2)) dutSat (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .fizz      (fizz),
    .buzz      (buzz),
    .fizzbuzz  (fizzbuzz),
    .locked    (lockedB),
    .index     (indexB),
    .mismatch  (mismatchB),
    .err_count (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    modelLocked = 1'b0;
    modelK      = 0;
    modelErrs   = 0;
    modelMis    = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit f, input bit b, input bit fb);
    bit sync;
    bit ef;
    bit eb;
    int k1;
    modelMis = 1'b0;
    if (v) begin
      sync = f && b && fb;
      if (!modelLocked) begin
        if (sync) begin
          modelLocked = 1'b1;
          modelK      = 0;
        end else if (fb != (f && b)) begin
          modelMis  = 1'b1;
          modelErrs = modelErrs + 1;
        end
      end else begin
        k1 = modelK + 1;
        ef = (k1 % FIZZ) == 0;
        eb = (k1 % BUZZ) == 0;
        if (f == ef && b == eb && fb == (ef && eb)) begin
          modelK = k1;
        end else begin
          modelMis  = 1'b1;
          modelErrs = modelErrs + 1;
          modelK    = 0;
          if (!sync) modelLocked = 1'b0;
        end
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount = assertCount + 1;
    assert (obs === exp) else begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      $error("[TB] %s deviated from model", tag);
    end
  endtask

  task automatic checkOutput();
    int expIdx;
    int expErrA;
    int expErrB;
    expIdx  = modelLocked ? (modelK % (FIZZ * BUZZ)) : 0;
    expErrA = (modelErrs > 255) ? 255 : modelErrs;
    expErrB = (modelErrs > 3) ? 3 : modelErrs;
    checkVal("locked",        32'(lockedA),   32'(modelLocked));
    checkVal("index",         32'(indexA),    32'(expIdx));
    checkVal("mismatch",      32'(mismatchA), 32'(modelMis));
    checkVal("err_count",     32'(errA),      32'(expErrA));
    checkVal("sat_locked",    32'(lockedB),   32'(modelLocked));
    checkVal("sat_err_count", 32'(errB),      32'(expErrB));
  endtask

  task automatic applyStimulus(input bit v, input bit f, input bit b, input bit fb);
    @(negedge clk);
    valid    = v;
    fizz     = f;
    buzz     = b;
    fizzbuzz = fb;
    @(posedge clk);
    modelStep(v, f, b, fb);
    #1;
    checkOutput();
  endtask

  task automatic genSample(input int n);
    applyStimulus(1'b1, (n % FIZZ) == 0, (n % BUZZ) == 0, (n % (FIZZ * BUZZ)) == 0);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    valid = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int gn;
    int roll;
    assertCount = 0;
    failCount   = 0;
    reset    = 1'b1;
    valid    = 1'b0;
    fizz     = 1'b0;
    buzz     = 1'b0;
    fizzbuzz = 1'b0;
    modelReset();
    #12;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] clean stream");
    for (int n = 0; n <= 30; n++) genSample(n);

    $display("[TB] dropped fizz");
    for (int n = 0; n <= 5; n++) genSample(n);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    genSample(0);

    $display("[TB] early sync");
    for (int n = 1; n <= 7; n++) genSample(n);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 3; n++) genSample(n);

    $display("[TB] valid gaps");
    for (int n = 4; n <= 5; n++) genSample(n);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    for (int n = 6; n <= 16; n++) genSample(n);

    $display("[TB] malformed in hunt");
    asyncReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    $display("[TB] saturation and async reset");
    asyncReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 4; n++) genSample(n);
    asyncReset();

    $display("[TB] randomised stream");
    gn = 0;
    for (int i = 0; i < 400; i++) begin
      roll = int'($urandom_range(0, 99));
      if (roll < 10) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
      end else if (roll < 16) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        gn = gn + 1;
      end else if (roll < 19) begin
        gn = 0;
        genSample(gn);
        gn = gn + 1;
      end else begin
        genSample(gn);
        gn = gn + 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
